// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: FSM encoding, access-size codes,
// byte-enable patterns and the bundle carried through a memory transaction.
package mem_stage_pkg;

  localparam int unsigned XLEN_P = 32;
  localparam int unsigned REG_AW = 5;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_GNT  = 2'd1;
  localparam logic [1:0] ST_WAIT_DATA = 2'd2;

  // funct3[1:0] selects size; funct3[2] marks an unsigned load.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef struct packed {
    logic [2:0]        funct3;
    logic [XLEN_P-1:0] addr;
    logic [XLEN_P-1:0] wdata;
    logic              is_load;
    logic              is_store;
    logic              we0;
    logic [REG_AW-1:0] rd0;
    logic [XLEN_P-1:0] alu1;
    logic              we1;
    logic [REG_AW-1:0] rd1;
  } bundle_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = addr_lo[0];
      default: mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data formatting: picks the addressed byte/halfword lane and extends it.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [1:0]        addr_lo,
  input  logic [XLEN_P-1:0] rdata,
  output logic [XLEN_P-1:0] data_c
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = 8'(rdata >> {addr_lo, 3'b000});
    lane_h = 16'(rdata >> {addr_lo[1], 4'b0000});
    case (funct3[1:0])
      SZ_BYTE: data_c = funct3[2] ? XLEN_P'(lane_b) : {{(XLEN_P-8){lane_b[7]}}, lane_b};
      SZ_HALF: data_c = funct3[2] ? XLEN_P'(lane_h) : {{(XLEN_P-16){lane_h[15]}}, lane_h};
      default: data_c = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: issues slot-0 loads/stores to data memory, stalls the
// front of the pipe until the access completes, and registers both writeback slots.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            valid_i,
  input  logic            mem_rd_i,
  input  logic            mem_wr_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic            we0_i,
  input  logic [4:0]      rd0_i,
  input  logic [XLEN-1:0] alu1_i,
  input  logic            we1_i,
  input  logic [4:0]      rd1_i,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [3:0]      dmem_be_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic            stall_o,
  output logic            misalign_o,
  output logic            wm0_o,
  output logic [4:0]      am0_o,
  output logic [XLEN-1:0] bypass_lsu0_o,
  output logic            wm1_o,
  output logic [4:0]      am1_o,
  output logic [XLEN-1:0] bypass_lsu1_o
);

  logic [1:0]        state, state_nxt;
  bundle_t           live, held, cur;
  logic              is_mem, mis_c, req_c, stall_c;
  logic [XLEN_P-1:0] load_data;

  // Bundle as seen on the EX/MEM latch; validity is folded into every enable.
  always_comb begin
    live          = '0;
    live.funct3   = funct3_i;
    live.addr     = addr_i;
    live.wdata    = wdata_i;
    live.is_load  = valid_i & mem_rd_i;
    live.is_store = valid_i & mem_wr_i;
    live.we0      = valid_i & we0_i;
    live.rd0      = rd0_i;
    live.alu1     = alu1_i;
    live.we1      = valid_i & we1_i;
    live.rd1      = rd1_i;
  end

  // Once a transaction is outstanding, everything is driven from the captured copy.
  assign cur    = (state == ST_IDLE) ? live : held;
  assign is_mem = live.is_load | live.is_store;
  assign mis_c  = (state == ST_IDLE) && is_mem
                  && is_misaligned(live.funct3[1:0], live.addr[1:0]);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Same-cycle gnt+rvalid completes a load without ever leaving the issuing state.
  always_comb begin
    state_nxt = state;
    req_c     = 1'b0;
    stall_c   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (is_mem && !mis_c) begin
          req_c = 1'b1;
          if (!dmem_gnt_i) begin
            state_nxt = ST_WAIT_GNT;
            stall_c   = 1'b1;
          end else if (live.is_load && !dmem_rvalid_i) begin
            state_nxt = ST_WAIT_DATA;
            stall_c   = 1'b1;
          end
        end
      end
      ST_WAIT_GNT: begin
        req_c   = 1'b1;
        stall_c = 1'b1;
        if (dmem_gnt_i) begin
          if (held.is_store || dmem_rvalid_i) begin
            state_nxt = ST_IDLE;
            stall_c   = 1'b0;
          end else begin
            state_nxt = ST_WAIT_DATA;
          end
        end
      end
      ST_WAIT_DATA: begin
        stall_c = 1'b1;
        if (dmem_rvalid_i) begin
          state_nxt = ST_IDLE;
          stall_c   = 1'b0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (!rst_n_i) begin
      state_nxt = ST_IDLE;
      req_c     = 1'b0;
      stall_c   = 1'b0;
    end
  end

  assign stall_o = stall_c;

  // Request payload: word-aligned address, lane enables and replicated store data.
  always_comb begin
    dmem_req_o  = req_c;
    dmem_we_o   = cur.is_store;
    dmem_addr_o = {cur.addr[XLEN_P-1:2], 2'b00};
    case (cur.funct3[1:0])
      SZ_BYTE: begin
        dmem_be_o    = BE_BYTE << cur.addr[1:0];
        dmem_wdata_o = {4{cur.wdata[7:0]}};
      end
      SZ_HALF: begin
        dmem_be_o    = BE_HALF << cur.addr[1:0];
        dmem_wdata_o = {2{cur.wdata[15:0]}};
      end
      default: begin
        dmem_be_o    = BE_WORD;
        dmem_wdata_o = cur.wdata;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                         held <= '0;
    else if (state == ST_IDLE && stall_c) held <= live;
  end

  load_align u_load_align (
    .funct3  (cur.funct3),
    .addr_lo (cur.addr[1:0]),
    .rdata   (dmem_rdata_i),
    .data_c  (load_data)
  );

  // Writeback registers advance only with the pipe; a stalled bundle writes nothing.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      misalign_o    <= 1'b0;
      wm0_o         <= 1'b0;
      am0_o         <= '0;
      bypass_lsu0_o <= '0;
      wm1_o         <= 1'b0;
      am1_o         <= '0;
      bypass_lsu1_o <= '0;
    end else if (stall_c) begin
      misalign_o <= 1'b0;
      wm0_o      <= 1'b0;
      wm1_o      <= 1'b0;
    end else begin
      misalign_o    <= mis_c;
      wm0_o         <= cur.we0 && (cur.rd0 != '0) && !cur.is_store && !mis_c;
      am0_o         <= cur.rd0;
      bypass_lsu0_o <= cur.is_load ? load_data : cur.addr;
      wm1_o         <= cur.we1 && (cur.rd1 != '0);
      am1_o         <= cur.rd1;
      bypass_lsu1_o <= cur.alu1;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: a cycle driver plays the data memory and queues the
// expected writeback of every bundle; a monitor checks each registered update.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n_i;
  logic        valid_i, mem_rd_i, mem_wr_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, wdata_i, alu1_i;
  logic        we0_i, we1_i;
  logic [4:0]  rd0_i, rd1_i;
  logic        dmem_req_o, dmem_we_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        stall_o, misalign_o;
  logic        wm0_o, wm1_o;
  logic [4:0]  am0_o, am1_o;
  logic [31:0] bypass_lsu0_o, bypass_lsu1_o;

  mem_stage #(.XLEN(32)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .valid_i(valid_i), .mem_rd_i(mem_rd_i),
    .mem_wr_i(mem_wr_i), .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .we0_i(we0_i), .rd0_i(rd0_i), .alu1_i(alu1_i), .we1_i(we1_i), .rd1_i(rd1_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_be_o(dmem_be_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i), .stall_o(stall_o),
    .misalign_o(misalign_o), .wm0_o(wm0_o), .am0_o(am0_o), .bypass_lsu0_o(bypass_lsu0_o),
    .wm1_o(wm1_o), .am1_o(am1_o), .bypass_lsu1_o(bypass_lsu1_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wm0;
    logic [4:0]  am0;
    logic [31:0] b0;
    logic        chk_b0;
    logic        wm1;
    logic [4:0]  am1;
    logic [31:0] b1;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  exp_t last;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   drv_active = 1'b0;
  bit   prev_stall = 1'b0;
  bit   mon_arm = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input int unsigned off,
                                           input logic [31:0] rdata);
    logic [31:0] v;
    case (f3)
      3'b000: begin v = (rdata >> (8*off)) & 32'hFF;   if (v >= 32'd128)   v = v + 32'hFFFFFF00; end
      3'b100: v = (rdata >> (8*off)) & 32'hFF;
      3'b001: begin v = (rdata >> (8*off)) & 32'hFFFF; if (v >= 32'd32768) v = v + 32'hFFFF0000; end
      3'b101: v = (rdata >> (8*off)) & 32'hFFFF;
      default: v = rdata;
    endcase
    return v;
  endfunction

  task automatic idle_inputs();
    valid_i = 0; mem_rd_i = 0; mem_wr_i = 0; funct3_i = 0; addr_i = 0; wdata_i = 0;
    we0_i = 0; rd0_i = 0; alu1_i = 0; we1_i = 0; rd1_i = 0;
    dmem_gnt_i = 0; dmem_rvalid_i = 0; dmem_rdata_i = 0;
  endtask

  // Called just after a rising edge; returns just after the rising edge that ends the bundle.
  task automatic run_bundle(input bit v, input bit rd, input bit wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input bit we0, input logic [4:0] rd0, input logic [31:0] alu1,
                            input bit we1, input logic [4:0] rd1,
                            input int g, input int d, input logic [31:0] rdata);
    int unsigned size, off;
    bit memop, mis, amem, load;
    int ncyc;
    exp_t e;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    size  = f3[1:0];
    off   = addr[1:0];
    memop = v && (rd || wr);
    mis   = memop && ((size == 1 && off[0]) || (size >= 2 && off != 0));
    amem  = memop && !mis;
    load  = amem && rd;
    if (g > 0 && d == 0) d = 1;
    ncyc  = !amem ? 1 : (wr ? g + 1 : g + d + 1);
    ebe   = (size == 0) ? 4'(1 << off) : (size == 1) ? 4'(3 << off) : 4'hF;
    ewd   = (size == 0) ? (wdata & 32'hFF) * 32'h01010101 :
            (size == 1) ? (wdata & 32'hFFFF) * 32'h00010001 : wdata;

    e.wm0    = v && we0 && rd0 != 0 && !wr && !mis;
    e.am0    = rd0;
    e.b0     = (v && rd && !mis) ? exp_load(f3, off, rdata) : addr;
    e.chk_b0 = !(v && rd && mis);
    e.wm1    = v && we1 && rd1 != 0;
    e.am1    = rd1;
    e.b1     = alu1;
    e.mis    = mis;
    exp_q.push_back(e);

    for (int c = 0; c < ncyc; c++) begin
      valid_i = v; mem_rd_i = rd; mem_wr_i = wr; funct3_i = f3; addr_i = addr; wdata_i = wdata;
      we0_i = we0; rd0_i = rd0; alu1_i = alu1; we1_i = we1; rd1_i = rd1;
      dmem_gnt_i = amem && (c == g);
      if (load && c == g + d) begin
        dmem_rvalid_i = 1; dmem_rdata_i = rdata;
      end else begin
        dmem_rvalid_i = (c < g || !load) && ($urandom_range(0, 3) == 0);
        dmem_rdata_i  = $urandom;
      end
      drv_active = 1'b1;
      @(negedge clk);
      check("stall", 32'(stall_o), 32'(c != ncyc - 1));
      check("req", 32'(dmem_req_o), 32'(amem && c <= g));
      if (amem && c <= g) begin
        check("req_addr", dmem_addr_o, addr & 32'hFFFFFFFC);
        check("req_be", 32'(dmem_be_o), 32'(ebe));
        check("req_we", 32'(dmem_we_o), 32'(wr));
        if (wr) check("req_wdata", dmem_wdata_o, ewd);
      end
      @(posedge clk); #1;
    end
  endtask

  // Monitor: after every unstalled cycle the registers must show the next queued bundle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_arm && rst_n_i) begin
        if (!prev_stall) begin
          if (exp_q.size() == 0) check("queue_underflow", 32'(exp_q.size()), 32'd1);
          else begin
            e = exp_q.pop_front();
            check("wm0", 32'(wm0_o), 32'(e.wm0));
            check("am0", 32'(am0_o), 32'(e.am0));
            if (e.chk_b0) check("bypass0", bypass_lsu0_o, e.b0);
            check("wm1", 32'(wm1_o), 32'(e.wm1));
            check("am1", 32'(am1_o), 32'(e.am1));
            check("bypass1", bypass_lsu1_o, e.b1);
            check("misalign", 32'(misalign_o), 32'(e.mis));
            last = e;
          end
        end else begin
          check("wm0_stalled", 32'(wm0_o), 32'd0);
          check("wm1_stalled", 32'(wm1_o), 32'd0);
          check("misalign_stalled", 32'(misalign_o), 32'd0);
          check("am1_hold", 32'(am1_o), 32'(last.am1));
          check("bypass1_hold", bypass_lsu1_o, last.b1);
          if (last.chk_b0) check("bypass0_hold", bypass_lsu0_o, last.b0);
        end
      end
      prev_stall = stall_o;
      mon_arm    = drv_active && rst_n_i;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int f3l[5];
    int f3s[3];
    int kind, g, d;
    logic [2:0] f3;
    f3l = '{0, 1, 2, 4, 5};
    f3s = '{0, 1, 2};
    idle_inputs();
    rst_n_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", 32'(dmem_req_o), 0);
    check("rst_stall", 32'(stall_o), 0);
    check("rst_misalign", 32'(misalign_o), 0);
    check("rst_wm0", 32'(wm0_o), 0);
    check("rst_wm1", 32'(wm1_o), 0);
    check("rst_am0", 32'(am0_o), 0);
    check("rst_am1", 32'(am1_o), 0);
    check("rst_bypass0", bypass_lsu0_o, 0);
    check("rst_bypass1", bypass_lsu1_o, 0);
    rst_n_i = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    run_bundle(1, 0, 0, 3'b000, 32'h11, 0, 1, 5'd1, 32'h22, 1, 5'd2, 0, 0, 0);
    run_bundle(1, 1, 0, 3'b010, 32'h100, 0, 1, 5'd5, 32'h0, 0, 5'd0, 0, 1, 32'hDEADBEEF);
    run_bundle(1, 0, 1, 3'b000, 32'h203, 32'hA5, 1, 5'd7, 32'h0, 0, 5'd0, 0, 0, 0);
    run_bundle(1, 1, 0, 3'b000, 32'h101, 0, 1, 5'd6, 32'h0, 0, 5'd0, 0, 1, 32'h00008000);
    run_bundle(1, 1, 0, 3'b100, 32'h101, 0, 1, 5'd6, 32'h0, 0, 5'd0, 0, 1, 32'h00008000);
    run_bundle(1, 1, 0, 3'b001, 32'h103, 0, 1, 5'd4, 32'h0, 0, 5'd0, 0, 1, 32'h0);
    run_bundle(1, 1, 0, 3'b010, 32'h300, 0, 1, 5'd8, 32'hCAFEF00D, 1, 5'd12, 3, 1, 32'h0BADF00D);
    run_bundle(1, 1, 0, 3'b001, 32'h102, 0, 1, 5'd9, 32'h0, 0, 5'd0, 0, 0, 32'h12345678);
    run_bundle(1, 1, 0, 3'b101, 32'h102, 0, 1, 5'd9, 32'h0, 0, 5'd0, 0, 2, 32'h80000000);
    run_bundle(1, 1, 0, 3'b001, 32'h102, 0, 1, 5'd9, 32'h0, 0, 5'd0, 1, 1, 32'h80000000);
    run_bundle(1, 0, 1, 3'b001, 32'h102, 32'h0000BEEF, 0, 5'd0, 32'h0, 0, 5'd0, 1, 0, 0);
    run_bundle(0, 0, 0, 3'b000, 32'h55, 0, 1, 5'd3, 32'h66, 1, 5'd3, 0, 0, 0);

    // Randomized bundles
    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 5);
      g    = $urandom_range(0, 3);
      d    = (g == 0) ? $urandom_range(0, 2) : $urandom_range(1, 2);
      if (kind >= 4) f3 = 3'(f3s[$urandom_range(0, 2)]);
      else           f3 = 3'(f3l[$urandom_range(0, 4)]);
      run_bundle(kind != 0, kind == 2 || kind == 3, kind >= 4, f3, $urandom, $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), g, d, $urandom);
    end
    run_bundle(1, 0, 0, 3'b000, 32'h1234, 0, 1, 5'd9, 32'h5555, 1, 5'd10, 0, 0, 0);

    // Reset in the middle of a load, then a late rvalid
    drv_active = 1'b0;
    valid_i = 1; mem_rd_i = 1; mem_wr_i = 0; funct3_i = 3'b010; addr_i = 32'h40;
    we0_i = 1; rd0_i = 5'd3; we1_i = 0; dmem_gnt_i = 1; dmem_rvalid_i = 0;
    @(negedge clk);
    check("rstmid_issue_stall", 32'(stall_o), 1);
    @(posedge clk); #1;
    dmem_gnt_i = 0;
    check("rstmid_wait_req", 32'(dmem_req_o), 0);
    check("rstmid_wait_stall", 32'(stall_o), 1);
    rst_n_i = 1'b0;
    #1;
    check("rstmid_req", 32'(dmem_req_o), 0);
    check("rstmid_stall", 32'(stall_o), 0);
    check("rstmid_misalign", 32'(misalign_o), 0);
    check("rstmid_wm0", 32'(wm0_o), 0);
    check("rstmid_wm1", 32'(wm1_o), 0);
    check("rstmid_am0", 32'(am0_o), 0);
    check("rstmid_am1", 32'(am1_o), 0);
    check("rstmid_bypass0", bypass_lsu0_o, 0);
    check("rstmid_bypass1", bypass_lsu1_o, 0);
    #1;
    rst_n_i = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    dmem_rvalid_i = 1; dmem_rdata_i = 32'h13572468;
    @(negedge clk);
    check("late_rvalid_stall", 32'(stall_o), 0);
    check("late_rvalid_req", 32'(dmem_req_o), 0);
    @(posedge clk); #1;
    dmem_rvalid_i = 0;
    check("late_rvalid_wm0", 32'(wm0_o), 0);
    check("late_rvalid_wm1", 32'(wm1_o), 0);

    run_bundle(1, 0, 0, 3'b000, 32'h77, 0, 1, 5'd11, 32'h88, 1, 5'd13, 0, 0, 0);
    drv_active = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    #1;
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
